rsa_vec_adder: RTL and testbench
================================

# rsa_vec_adder

Parametrised, multi-lane successor to the single-lane synchronous adder in the RSA datapath. Each lane computes C, M+C, C−M or M−C, with optional saturation. Two accumulate modes reduce a programmable number of input beats into one result. Inputs and outputs use valid/ready handshakes with a single registered output stage, so the block can sit between the systolic array outputs and the matrix-update buffers under backpressure.

## Interface
Parameters:
- RSA_DW, 16, lane data width (two's complement)
- LANES, 4, number of parallel lanes
- SAT, 1, 1 = saturate results to RSA_DW; 0 = wrap (truncate)
- CNT_W, 8, width of accumulate length field

Ports:
- clk  in  1  single clock; all state updates on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- mode  in  3  operation; sampled on accepted beats (see Operation)
- acc_len  in  CNT_W  beats per accumulation; sampled on first beat of an accumulation
- adder_M  in  LANES*RSA_DW  signed operands, lane i at bits [i*RSA_DW +: RSA_DW]
- adder_C  in  LANES*RSA_DW  signed operands, same packing
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  LANES*RSA_DW  signed results, same packing
- ovf  out  LANES  per-lane overflow flag for the current result

## Operation
- Modes:
  - 000 NONE: C
  - 001 ADD: M+C
  - 010 C_MINUS_M: C−M
  - 011 M_MINUS_C: M−C
  - 100 ACC: Σ(M+C)
  - 101 ACC_SUB: Σ(C−M)
  - 110 and 111: reserved, treated as NONE
- States are IDLE and ACC.
- IDLE, non-accumulate mode accepted: per-lane result is loaded into the output register and out_valid is set.
- IDLE, ACC or ACC_SUB accepted: mode is latched, acc_len is latched (0 treated as 1), the accumulator is loaded with the first term and cnt=1.
  - If len=1, the result goes straight to the output and the state stays IDLE.
  - Otherwise the state goes to ACC.
- ACC: each accepted beat adds its term (per the latched mode); the mode and acc_len inputs are ignored.
  - When cnt reaches len, the result is loaded into the output, cnt is cleared, and the state returns to IDLE.
- Arithmetic:
  - Element-wise results are computed at RSA_DW+1 bits.
  - The accumulator is RSA_DW+CNT_W+1 bits per lane, so it never wraps internally.
  - The final value is reduced to RSA_DW: if SAT=1, clamp to [−2^(RSA_DW−1), 2^(RSA_DW−1)−1]; otherwise keep the low RSA_DW bits.
  - ovf[i]=1 when the full-precision value is out of range, whichever of saturation or wrap applies.
- in_ready = sys_rst_n && (output free || beat will not produce a result).
  - Output free: !out_valid || out_ready.
  - Beat will not produce a result: state==ACC && cnt != len−1.
- Output hold: sum and ovf are held stable while out_valid && !out_ready.
- Simultaneous events: a result consumed and a new result loaded in the same cycle keeps out_valid=1 with the new data.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - sum=0, ovf=0, out_valid=0, state IDLE, cnt=0, accumulator=0.
  - in_ready=0 while sys_rst_n is low.
- Reset during ACC discards the partial sum; no output is produced.
- Latency, element-wise modes: 1 cycle from accepted beat to out_valid.
- Latency, accumulate modes: 1 cycle after the last (len-th) accepted beat.
- Throughput: 1 beat/cycle when out_ready is held high.

## Structure
- Package rsa_adder_pkg holds:
  - mode localparams (NONE, ADD, C_MINUS_M, M_MINUS_C, ACC, ACC_SUB)
  - a state encoding
  - a saturate/overflow function
- Sub-module rsa_lane_alu holds the per-lane logic: operand select, add/sub, accumulator register, final reduction and ovf. It is instantiated LANES times by a generate loop.
- The top level holds the FSM, cnt, latched mode/len, the handshake and the output register.

## Test plan
All cases use RSA_DW=16 and LANES=2.
- ADD, lane0 M=100 C=−30, lane1 M=−5 C=−7 -> sum={−12,70} one cycle after accept, ovf=0.
- ADD M=32767 C=1: SAT=1 -> 32767, ovf=1; SAT=0 -> −32768, ovf=1. C_MINUS_M with C=−32768 M=1 under SAT=1 -> −32768, ovf=1.
- ACC, acc_len=4, lane0 M=1,2,3,4 with C=10 -> exactly one out_valid, sum0=50, one cycle after the 4th beat; mode changes on beats 2–4 are ignored. acc_len=0 behaves as 1.
- out_ready=0 with 3 back-to-back ADD beats -> one result held stable, in_ready=0 from the 2nd beat; releasing out_ready delivers all 3 results in order with no loss.
- Reset asserted after 2 of 4 ACC beats -> all outputs 0 immediately; after release, a fresh ACC with acc_len=2 (M=1,1, C=0) -> sum0=2.
- mode=110 with C=7 -> sum=7, ovf=0.

Source files
------------

// File: rtl/rsa_adder_pkg.sv
// Shared definitions for the multi-lane RSA vector adder: mode codes,
// controller state encoding and the range check used by the final reduction.
package rsa_adder_pkg;

  localparam logic [2:0] MODE_NONE      = 3'b000;
  localparam logic [2:0] MODE_ADD       = 3'b001;
  localparam logic [2:0] MODE_C_MINUS_M = 3'b010;
  localparam logic [2:0] MODE_M_MINUS_C = 3'b011;
  localparam logic [2:0] MODE_ACC       = 3'b100;
  localparam logic [2:0] MODE_ACC_SUB   = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Width of the sign-extended value handed to the range check; lanes
  // extend their full-precision result to this width before calling it.
  localparam int unsigned RED_W = 64;

  // Returns {above_max, below_min} for a value against a dw-bit signed range.
  // Either bit set means the result overflows, whether it is clamped or wrapped.
  function automatic logic [1:0] range_chk(input logic signed [RED_W-1:0] v,
                                           input int unsigned dw);
    logic signed [RED_W-1:0] max_v;
    logic signed [RED_W-1:0] min_v;
    max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (dw - 1));
    range_chk = {(v > max_v), (v < min_v)};
  endfunction

endpackage

// File: rtl/rsa_lane_alu.sv
// One lane of the vector adder: operand select, add/sub with a guard bit,
// wide accumulator, and reduction of the final value to RSA_DW with ovf.
module rsa_lane_alu
  import rsa_adder_pkg::*;
#(
  parameter int RSA_DW = 16,
  parameter int CNT_W  = 8,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        op_mode_i,
  input  logic [RSA_DW-1:0] m_i,
  input  logic [RSA_DW-1:0] c_i,
  input  logic              acc_en_i,
  input  logic              acc_first_i,
  input  logic              use_acc_i,
  output logic [RSA_DW-1:0] res_o,
  output logic              ovf_o
);

  localparam int TW = RSA_DW + 1;
  localparam int AW = RSA_DW + CNT_W + 1;

  localparam logic [RSA_DW-1:0] MAX_V = {1'b0, {(RSA_DW-1){1'b1}}};
  localparam logic [RSA_DW-1:0] MIN_V = {1'b1, {(RSA_DW-1){1'b0}}};

  logic signed [TW-1:0]    m_x, c_x, term;
  logic signed [AW-1:0]    term_x, acc_q, acc_d;
  logic signed [RED_W-1:0] full;
  logic [1:0]              rng;

  assign m_x    = {m_i[RSA_DW-1], m_i};
  assign c_x    = {c_i[RSA_DW-1], c_i};
  assign term_x = {{(AW-TW){term[TW-1]}}, term};

  // Element-wise term; reserved codes fall back to passing C through
  always_comb begin
    case (op_mode_i)
      MODE_ADD, MODE_ACC:           term = m_x + c_x;
      MODE_C_MINUS_M, MODE_ACC_SUB: term = c_x - m_x;
      MODE_M_MINUS_C:               term = m_x - c_x;
      default:                      term = c_x;
    endcase
  end

  // Running sum including the current beat; the first beat restarts it
  always_comb begin
    if (acc_first_i) acc_d = term_x;
    else             acc_d = acc_q + term_x;
  end

  // Pick the full-precision value and reduce it to the lane width
  always_comb begin
    if (use_acc_i) full = {{(RED_W-AW){acc_d[AW-1]}}, acc_d};
    else           full = {{(RED_W-TW){term[TW-1]}}, term};
    rng   = range_chk(full, RSA_DW);
    ovf_o = |rng;
    if (SAT && rng[1])      res_o = MAX_V;
    else if (SAT && rng[0]) res_o = MIN_V;
    else                    res_o = full[RSA_DW-1:0];
  end

  // Accumulator advances only on accepted accumulate beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc_q <= '0;
    else if (acc_en_i) acc_q <= acc_d;
  end

endmodule

// File: rtl/rsa_vec_adder.sv
// Multi-lane vector adder with accumulate modes and a single registered,
// backpressure-aware output stage.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no accumulation open; any beat starts a new operation
//   ST_ACC  | accumulation open; beats add to the sum until cnt hits len
module rsa_vec_adder
  import rsa_adder_pkg::*;
#(
  parameter int RSA_DW = 16,
  parameter int LANES  = 4,
  parameter bit SAT    = 1'b1,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    sys_rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              mode,
  input  logic [CNT_W-1:0]        acc_len,
  input  logic [LANES*RSA_DW-1:0] adder_M,
  input  logic [LANES*RSA_DW-1:0] adder_C,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*RSA_DW-1:0] sum,
  output logic [LANES-1:0]        ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q, len_q, len_in;
  logic [2:0]              mode_q, op_mode;
  logic                    out_valid_q;
  logic [LANES*RSA_DW-1:0] sum_q, res_w;
  logic [LANES-1:0]        ovf_q, ovf_w;
  logic                    is_acc_in, out_free, no_result, accept;
  logic                    acc_first, acc_beat, use_acc, last_beat, produce;

  assign len_in    = (acc_len == '0) ? CNT_ONE : acc_len;
  assign is_acc_in = (mode == MODE_ACC) || (mode == MODE_ACC_SUB);
  assign last_beat = (cnt_q == len_q - CNT_ONE);
  assign out_free  = !out_valid_q || out_ready;
  // A mid-accumulation beat never touches the output register, so it can be
  // taken even while a result is stalled downstream.
  assign no_result = (state_q == ST_ACC) && !last_beat;
  assign in_ready  = sys_rst_n && (out_free || no_result);
  assign accept    = in_valid && in_ready;

  assign use_acc   = (state_q == ST_ACC) || is_acc_in;
  assign op_mode   = (state_q == ST_ACC) ? mode_q : mode;
  assign acc_first = accept && (state_q == ST_IDLE) && is_acc_in;
  assign acc_beat  = accept && use_acc;

  // An accepted beat yields a result unless it opens or continues a longer accumulation
  always_comb begin
    produce = 1'b0;
    if (accept) begin
      if (state_q == ST_IDLE) produce = !is_acc_in || (len_in == CNT_ONE);
      else                    produce = last_beat;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rsa_lane_alu #(
      .RSA_DW (RSA_DW),
      .CNT_W  (CNT_W),
      .SAT    (SAT)
    ) u_lane (
      .clk         (clk),
      .rst_n       (sys_rst_n),
      .op_mode_i   (op_mode),
      .m_i         (adder_M[g*RSA_DW +: RSA_DW]),
      .c_i         (adder_C[g*RSA_DW +: RSA_DW]),
      .acc_en_i    (acc_beat),
      .acc_first_i (acc_first),
      .use_acc_i   (use_acc),
      .res_o       (res_w[g*RSA_DW +: RSA_DW]),
      .ovf_o       (ovf_w[g])
    );
  end

  // Controller FSM, beat counter, latched mode/len and output register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= CNT_ONE;
      mode_q      <= MODE_NONE;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= '0;
    end else begin
      if (produce) begin
        out_valid_q <= 1'b1;
        sum_q       <= res_w;
        ovf_q       <= ovf_w;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        if (state_q == ST_IDLE) begin
          if (is_acc_in) begin
            mode_q <= mode;
            len_q  <= len_in;
            if (len_in == CNT_ONE) begin
              cnt_q <= '0;
            end else begin
              cnt_q   <= CNT_ONE;
              state_q <= ST_ACC;
            end
          end
        end else if (last_beat) begin
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rsa_vec_adder.sv
// Directed bench for rsa_vec_adder with two lanes; a second instance built
// with SAT=0 shares the stimulus so wrap behaviour is checked alongside.
module tb_rsa_vec_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  mode;
  logic [7:0]  acc_len;
  logic [31:0] adder_M, adder_C;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [31:0] sum;
  logic [1:0]  ovf;
  logic        in_ready_w, out_valid_w;
  logic [31:0] sum_w;
  logic [1:0]  ovf_w;

  int errors = 0;
  int checks = 0;

  rsa_vec_adder #(.RSA_DW(16), .LANES(2), .SAT(1'b1), .CNT_W(8)) dut (
    .clk(clk), .sys_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .acc_len(acc_len), .adder_M(adder_M), .adder_C(adder_C),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .ovf(ovf)
  );

  rsa_vec_adder #(.RSA_DW(16), .LANES(2), .SAT(1'b0), .CNT_W(8)) dut_w (
    .clk(clk), .sys_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .mode(mode), .acc_len(acc_len), .adder_M(adder_M), .adder_C(adder_C),
    .out_valid(out_valid_w), .out_ready(out_ready), .sum(sum_w), .ovf(ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [2:0] md, input logic [7:0] len,
                          input logic [15:0] m0, input logic [15:0] c0,
                          input logic [15:0] m1, input logic [15:0] c1);
    in_valid = 1'b1;
    mode     = md;
    acc_len  = len;
    adder_M  = {m1, m0};
    adder_C  = {c1, c0};
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    mode     = 3'b000;
    acc_len  = 8'd0;
    adder_M  = '0;
    adder_C  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum got=%h exp=00000000", sum); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf got=%b exp=00", ovf); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    set_beat(3'b001, 8'd0, 16'd100, -16'sd30, -16'sd5, -16'sd7);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
    tick();
    idle_in();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (sum !== {16'hFFF4, 16'd70}) begin errors++; $display("FAIL add_sum got=%h exp=fff40046", sum); end
    checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL add_ovf got=%b exp=00", ovf); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_saturate();
    set_beat(3'b001, 8'd0, 16'd32767, 16'd1, 16'd0, 16'd0);
    tick();
    checks++; if (sum[15:0] !== 16'h7FFF || ovf !== 2'b01) begin errors++; $display("FAIL sat_add_hi got=%h ovf=%b exp=7fff ovf=01", sum[15:0], ovf); end
    checks++; if (sum_w[15:0] !== 16'h8000 || ovf_w !== 2'b01) begin errors++; $display("FAIL wrap_add_hi got=%h ovf=%b exp=8000 ovf=01", sum_w[15:0], ovf_w); end
    set_beat(3'b010, 8'd0, 16'd1, 16'h8000, 16'd0, 16'd0);
    tick();
    checks++; if (sum[15:0] !== 16'h8000 || ovf !== 2'b01) begin errors++; $display("FAIL sat_cmm_lo got=%h ovf=%b exp=8000 ovf=01", sum[15:0], ovf); end
    checks++; if (sum_w[15:0] !== 16'h7FFF || ovf_w !== 2'b01) begin errors++; $display("FAIL wrap_cmm_lo got=%h ovf=%b exp=7fff ovf=01", sum_w[15:0], ovf_w); end
    // M-C: lane0 5-8=-3, lane1 -32768-1 underflows
    set_beat(3'b011, 8'd0, 16'd5, 16'd8, 16'h8000, 16'd1);
    tick();
    idle_in();
    checks++; if (sum !== {16'h8000, 16'hFFFD} || ovf !== 2'b10) begin errors++; $display("FAIL sat_mmc got=%h ovf=%b exp=8000fffd ovf=10", sum, ovf); end
    checks++; if (sum_w !== {16'h7FFF, 16'hFFFD} || ovf_w !== 2'b10) begin errors++; $display("FAIL wrap_mmc got=%h ovf=%b exp=7ffffffd ovf=10", sum_w, ovf_w); end
    tick();
  endtask

  task automatic test_accumulate();
    logic [2:0] noise [4];
    noise[0] = 3'b100; noise[1] = 3'b001; noise[2] = 3'b000; noise[3] = 3'b010;
    for (int b = 0; b < 4; b++) begin
      set_beat(noise[b], (b == 0) ? 8'd4 : 8'd1, 16'(b + 1), 16'd10, 16'd0, 16'd0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL acc_in_ready beat=%0d got=%b exp=1", b, in_ready); end
      tick();
      if (b < 3) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_early_valid beat=%0d got=%b exp=0", b, out_valid); end
      end
    end
    idle_in();
    checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd50) begin errors++; $display("FAIL acc_result valid=%b got=%0d exp=50", out_valid, sum[15:0]); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL acc_single_result got=%b exp=0", out_valid); end
    // acc_len=0 is a one-beat accumulation
    set_beat(3'b100, 8'd0, 16'd5, 16'd6, 16'd0, 16'd0);
    tick();
    idle_in();
    checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd11) begin errors++; $display("FAIL acc_len0 valid=%b got=%0d exp=11", out_valid, sum[15:0]); end
    // ACC_SUB over two beats: (10-3) + (1-4) = 4
    set_beat(3'b101, 8'd2, 16'd3, 16'd10, 16'd0, 16'd0);
    tick();
    set_beat(3'b001, 8'd9, 16'd4, 16'd1, 16'd0, 16'd0);
    tick();
    idle_in();
    checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd4) begin errors++; $display("FAIL acc_sub valid=%b got=%0d exp=4", out_valid, sum[15:0]); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    set_beat(3'b001, 8'd0, 16'd1, 16'd1, 16'd0, 16'd0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got=%b exp=1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd2) begin errors++; $display("FAIL bp_first valid=%b got=%0d exp=2", out_valid, sum[15:0]); end
    set_beat(3'b001, 8'd0, 16'd2, 16'd2, 16'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd2) begin errors++; $display("FAIL bp_hold cyc=%0d valid=%b got=%0d exp=2", k, out_valid, sum[15:0]); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd4) begin errors++; $display("FAIL bp_second valid=%b got=%0d exp=4", out_valid, sum[15:0]); end
    set_beat(3'b001, 8'd0, 16'd3, 16'd3, 16'd0, 16'd0);
    tick();
    idle_in();
    checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd6) begin errors++; $display("FAIL bp_third valid=%b got=%0d exp=6", out_valid, sum[15:0]); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_acc();
    set_beat(3'b100, 8'd4, 16'd7, 16'd0, 16'd0, 16'd0);
    tick(); tick();
    idle_in();
    rst_n = 1'b0;
    #1;
    checks++; if (sum !== 32'h0 || ovf !== 2'b00 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_acc_outputs sum=%h ovf=%b valid=%b exp=0", sum, ovf, out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_acc_in_ready got=%b exp=0", in_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    set_beat(3'b100, 8'd2, 16'd1, 16'd0, 16'd0, 16'd0);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_acc_early got=%b exp=0", out_valid); end
    tick();
    idle_in();
    checks++; if (out_valid !== 1'b1 || sum[15:0] !== 16'd2) begin errors++; $display("FAIL rst_acc_fresh valid=%b got=%0d exp=2", out_valid, sum[15:0]); end
    tick();
  endtask

  task automatic test_reserved();
    set_beat(3'b110, 8'd0, 16'd3, 16'd7, 16'd9, -16'sd2);
    tick();
    checks++; if (sum !== {16'hFFFE, 16'd7} || ovf !== 2'b00) begin errors++; $display("FAIL rsv110 got=%h ovf=%b exp=fffe0007 ovf=00", sum, ovf); end
    set_beat(3'b111, 8'd0, 16'd3, 16'd12, 16'd9, 16'd0);
    tick();
    idle_in();
    checks++; if (sum !== {16'd0, 16'd12} || out_valid !== 1'b1) begin errors++; $display("FAIL rsv111 got=%h valid=%b exp=0000000c", sum, out_valid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_saturate();
    test_accumulate();
    test_back_to_back();
    test_reset_mid_acc();
    test_reserved();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
